// File: rtl/iob_axi_master_bridge.sv
// Native IOb request port to AXI4 master bridge.
// One single-beat transaction is in flight at a time; every AXI field that
// the native side has no notion of (burst length, cache, QoS, ...) is fixed.
module iob_axi_master_bridge #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int ID_W   = 8,
   parameter int LEN_W  = 8,
   parameter int AXI_ID = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // native side
   input  logic                  iob_valid_i,
   input  logic [ADDR_W-1:0]     iob_addr_i,
   input  logic [DATA_W-1:0]     iob_wdata_i,
   input  logic [DATA_W/8-1:0]   iob_wstrb_i,
   output logic                  iob_ready_o,
   output logic                  iob_rvalid_o,
   output logic [DATA_W-1:0]     iob_rdata_o,
   output logic                  iob_err_o,
   // AXI write address
   output logic [ID_W-1:0]       axi_awid_o,
   output logic [ADDR_W-1:0]     axi_awaddr_o,
   output logic [LEN_W-1:0]      axi_awlen_o,
   output logic [2:0]            axi_awsize_o,
   output logic [1:0]            axi_awburst_o,
   output logic                  axi_awlock_o,
   output logic [3:0]            axi_awcache_o,
   output logic [2:0]            axi_awprot_o,
   output logic [3:0]            axi_awqos_o,
   output logic                  axi_awvalid_o,
   input  logic                  axi_awready_i,
   // AXI write data
   output logic [DATA_W-1:0]     axi_wdata_o,
   output logic [DATA_W/8-1:0]   axi_wstrb_o,
   output logic                  axi_wlast_o,
   output logic                  axi_wvalid_o,
   input  logic                  axi_wready_i,
   // AXI write response
   input  logic [ID_W-1:0]       axi_bid_i,
   input  logic [1:0]            axi_bresp_i,
   input  logic                  axi_bvalid_i,
   output logic                  axi_bready_o,
   // AXI read address
   output logic [ID_W-1:0]       axi_arid_o,
   output logic [ADDR_W-1:0]     axi_araddr_o,
   output logic [LEN_W-1:0]      axi_arlen_o,
   output logic [2:0]            axi_arsize_o,
   output logic [1:0]            axi_arburst_o,
   output logic                  axi_arlock_o,
   output logic [3:0]            axi_arcache_o,
   output logic [2:0]            axi_arprot_o,
   output logic [3:0]            axi_arqos_o,
   output logic                  axi_arvalid_o,
   input  logic                  axi_arready_i,
   // AXI read data
   input  logic [ID_W-1:0]       axi_rid_i,
   input  logic [DATA_W-1:0]     axi_rdata_i,
   input  logic [1:0]            axi_rresp_i,
   input  logic                  axi_rlast_i,
   input  logic                  axi_rvalid_i,
   output logic                  axi_rready_o
);

   localparam int STRB_W = DATA_W / 8;
   localparam int SIZE   = $clog2(STRB_W);
   // Clears the byte-offset bits so the AXI address is bus-width aligned.
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~(ADDR_W'(STRB_W - 1));

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_DATA
   } state_t;

   state_t              state_q, state_d;
   logic                ready_q, ready_d;
   logic                aw_done_q, aw_done_d;
   logic                w_done_q, w_done_d;
   logic                rvalid_q, rvalid_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;

   logic                accept;
   logic                aw_hs;
   logic                w_hs;
   logic                ar_hs;

   // IDs are fixed on issue and only one transaction is outstanding, so the
   // returned IDs carry no information.
   logic                unused_ids;
   assign unused_ids = ^{axi_bid_i, axi_rid_i};

   assign accept = iob_valid_i & ready_q;
   assign aw_hs  = axi_awvalid_o & axi_awready_i;
   assign w_hs   = axi_wvalid_o & axi_wready_i;
   assign ar_hs  = axi_arvalid_o & axi_arready_i;

   // Next-state logic: transaction sequencing, capture and error tracking.
   always_comb begin
      state_d   = state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rvalid_d  = 1'b0;
      rdata_d   = rdata_q;
      err_d     = err_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               addr_d    = iob_addr_i;
               wdata_d   = iob_wdata_i;
               wstrb_d   = iob_wstrb_i;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = (|iob_wstrb_i) ? WR_REQ : RD_REQ;
            end
         end
         WR_REQ: begin
            // AW and W complete independently; wait until both have.
            if (aw_hs) aw_done_d = 1'b1;
            if (w_hs)  w_done_d  = 1'b1;
            if (aw_done_d && w_done_d) state_d = WR_RESP;
         end
         WR_RESP: begin
            if (axi_bvalid_i) begin
               state_d = IDLE;
               if (axi_bresp_i != 2'b00) err_d = 1'b1;
            end
         end
         RD_REQ: begin
            if (ar_hs) state_d = RD_DATA;
         end
         RD_DATA: begin
            if (axi_rvalid_i) begin
               state_d  = IDLE;
               rvalid_d = 1'b1;
               rdata_d  = axi_rdata_i;
               if ((axi_rresp_i != 2'b00) || !axi_rlast_i) err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   // Control state register; a reset abandons any transaction in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   // Request payload; only meaningful while a transaction is active.
   always_ff @(posedge clk_i) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
   end

   assign iob_ready_o   = ready_q;
   assign iob_rvalid_o  = rvalid_q;
   assign iob_rdata_o   = rdata_q;
   assign iob_err_o     = err_q;

   assign axi_awid_o    = ID_W'(AXI_ID);
   assign axi_awaddr_o  = addr_q & ADDR_MASK;
   assign axi_awlen_o   = '0;
   assign axi_awsize_o  = 3'(SIZE);
   assign axi_awburst_o = 2'b01;
   assign axi_awlock_o  = 1'b0;
   assign axi_awcache_o = 4'd0;
   assign axi_awprot_o  = 3'd0;
   assign axi_awqos_o   = 4'd0;
   assign axi_awvalid_o = (state_q == WR_REQ) && !aw_done_q;

   assign axi_wdata_o   = wdata_q;
   assign axi_wstrb_o   = wstrb_q;
   assign axi_wlast_o   = 1'b1;
   assign axi_wvalid_o  = (state_q == WR_REQ) && !w_done_q;

   assign axi_bready_o  = (state_q == WR_RESP);

   assign axi_arid_o    = ID_W'(AXI_ID);
   assign axi_araddr_o  = addr_q & ADDR_MASK;
   assign axi_arlen_o   = '0;
   assign axi_arsize_o  = 3'(SIZE);
   assign axi_arburst_o = 2'b01;
   assign axi_arlock_o  = 1'b0;
   assign axi_arcache_o = 4'd0;
   assign axi_arprot_o  = 3'd0;
   assign axi_arqos_o   = 4'd0;
   assign axi_arvalid_o = (state_q == RD_REQ);

   assign axi_rready_o  = (state_q == RD_DATA);

endmodule

// File: tb/tb_iob_axi_master_bridge.sv
// Directed bench for iob_axi_master_bridge: the AXI slave is driven by hand
// cycle by cycle and every output is compared with hand-computed values.
module tb_iob_axi_master_bridge;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 32;
   localparam int ID_W   = 8;
   localparam int LEN_W  = 8;

   logic clk = 1'b0;
   logic rst;

   logic              iob_valid;
   logic [ADDR_W-1:0] iob_addr;
   logic [DATA_W-1:0] iob_wdata;
   logic [3:0]        iob_wstrb;
   logic              iob_ready;
   logic              iob_rvalid;
   logic [DATA_W-1:0] iob_rdata;
   logic              iob_err;

   logic [ID_W-1:0]   awid, arid;
   logic [ADDR_W-1:0] awaddr, araddr;
   logic [LEN_W-1:0]  awlen, arlen;
   logic [2:0]        awsize, arsize, awprot, arprot;
   logic [1:0]        awburst, arburst;
   logic              awlock, arlock;
   logic [3:0]        awcache, arcache, awqos, arqos;
   logic              awvalid, awready, arvalid, arready;
   logic [DATA_W-1:0] wdata;
   logic [3:0]        wstrb;
   logic              wlast, wvalid, wready;
   logic [ID_W-1:0]   bid, rid;
   logic [1:0]        bresp, rresp;
   logic              bvalid, bready;
   logic [DATA_W-1:0] rdata;
   logic              rlast, rvalid, rready;

   int n_chk  = 0;
   int n_pass = 0;

   iob_axi_master_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W), .AXI_ID(0)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .iob_valid_i(iob_valid), .iob_addr_i(iob_addr), .iob_wdata_i(iob_wdata),
      .iob_wstrb_i(iob_wstrb), .iob_ready_o(iob_ready), .iob_rvalid_o(iob_rvalid),
      .iob_rdata_o(iob_rdata), .iob_err_o(iob_err),
      .axi_awid_o(awid), .axi_awaddr_o(awaddr), .axi_awlen_o(awlen),
      .axi_awsize_o(awsize), .axi_awburst_o(awburst), .axi_awlock_o(awlock),
      .axi_awcache_o(awcache), .axi_awprot_o(awprot), .axi_awqos_o(awqos),
      .axi_awvalid_o(awvalid), .axi_awready_i(awready),
      .axi_wdata_o(wdata), .axi_wstrb_o(wstrb), .axi_wlast_o(wlast),
      .axi_wvalid_o(wvalid), .axi_wready_i(wready),
      .axi_bid_i(bid), .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready),
      .axi_arid_o(arid), .axi_araddr_o(araddr), .axi_arlen_o(arlen),
      .axi_arsize_o(arsize), .axi_arburst_o(arburst), .axi_arlock_o(arlock),
      .axi_arcache_o(arcache), .axi_arprot_o(arprot), .axi_arqos_o(arqos),
      .axi_arvalid_o(arvalid), .axi_arready_i(arready),
      .axi_rid_i(rid), .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rlast_i(rlast),
      .axi_rvalid_i(rvalid), .axi_rready_o(rready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      iob_valid = 0; iob_addr = '0; iob_wdata = '0; iob_wstrb = '0;
      awready = 0; wready = 0; arready = 0;
      bid = '0; bresp = 2'b00; bvalid = 0;
      rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 0;

      // ---------------- reset state
      tick(); tick();
      chk("rst_ready", iob_ready, 0);
      chk("rst_awvalid", awvalid, 0);
      chk("rst_wvalid", wvalid, 0);
      chk("rst_arvalid", arvalid, 0);
      chk("rst_bready", bready, 0);
      chk("rst_rready", rready, 0);
      chk("rst_rvalid", iob_rvalid, 0);
      chk("rst_rdata", iob_rdata, 0);
      chk("rst_err", iob_err, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_ready", iob_ready, 1);

      // ---------------- write, slave ready immediately
      iob_valid = 1; iob_addr = 16'h0012; iob_wdata = 32'hDEADBEEF; iob_wstrb = 4'hF;
      awready = 1; wready = 1;
      tick();
      iob_valid = 0;
      chk("w1_ready_low", iob_ready, 0);
      chk("w1_awvalid", awvalid, 1);
      chk("w1_wvalid", wvalid, 1);
      chk("w1_awaddr", awaddr, 16'h0010);
      chk("w1_wdata", wdata, 32'hDEADBEEF);
      chk("w1_wstrb", wstrb, 4'hF);
      chk("w1_wlast", wlast, 1);
      chk("w1_awlen", awlen, 0);
      chk("w1_awsize", awsize, 2);
      chk("w1_awburst", awburst, 2'b01);
      chk("w1_awid", awid, 0);
      chk("w1_awmisc", {awlock, awcache, awprot, awqos}, 0);
      tick();
      chk("w1_awvalid_drop", awvalid, 0);
      chk("w1_wvalid_drop", wvalid, 0);
      chk("w1_bready", bready, 1);
      chk("w1_ready_wresp", iob_ready, 0);
      bvalid = 1; bresp = 2'b00;
      tick();
      bvalid = 0;
      chk("w1_ready_back", iob_ready, 1);
      chk("w1_bready_off", bready, 0);
      chk("w1_err", iob_err, 0);

      // ---------------- read, data returned 3 cycles late
      iob_valid = 1; iob_addr = 16'h0010; iob_wstrb = 4'h0; arready = 1;
      tick();
      iob_valid = 0;
      chk("r1_arvalid", arvalid, 1);
      chk("r1_araddr", araddr, 16'h0010);
      chk("r1_arlen", arlen, 0);
      chk("r1_arsize", arsize, 2);
      chk("r1_arburst", arburst, 2'b01);
      chk("r1_awvalid", awvalid, 0);
      tick();
      chk("r1_arvalid_drop", arvalid, 0);
      for (int i = 0; i < 3; i++) begin
         chk("r1_rready_wait", rready, 1);
         chk("r1_rvalid_wait", iob_rvalid, 0);
         tick();
      end
      rvalid = 1; rdata = 32'hDEADBEEF; rresp = 2'b00; rlast = 1;
      tick();
      rvalid = 0;
      chk("r1_rvalid", iob_rvalid, 1);
      chk("r1_rdata", iob_rdata, 32'hDEADBEEF);
      chk("r1_ready", iob_ready, 1);
      chk("r1_rready_off", rready, 0);
      tick();
      chk("r1_rvalid_pulse", iob_rvalid, 0);
      chk("r1_err", iob_err, 0);

      // ---------------- write, awready 4 cycles late, wready immediate
      awready = 0; wready = 1;
      iob_valid = 1; iob_addr = 16'h0027; iob_wdata = 32'h01020304; iob_wstrb = 4'h3;
      tick();
      iob_valid = 0;
      chk("w2_awvalid_t1", awvalid, 1);
      chk("w2_wvalid_t1", wvalid, 1);
      for (int i = 2; i <= 5; i++) begin
         tick();
         chk("w2_awvalid_hold", awvalid, 1);
         chk("w2_wvalid_off", wvalid, 0);
         chk("w2_awaddr_stable", awaddr, 16'h0024);
         chk("w2_bready_off", bready, 0);
      end
      awready = 1;
      tick();
      awready = 0;
      chk("w2_awvalid_drop", awvalid, 0);
      chk("w2_bready", bready, 1);
      bvalid = 1; bresp = 2'b00;
      tick();
      bvalid = 0;
      chk("w2_ready", iob_ready, 1);
      tick();
      chk("w2_single_b", bready, 0);

      // ---------------- bresp error is sticky across a good read
      awready = 1; wready = 1;
      iob_valid = 1; iob_addr = 16'h0030; iob_wdata = 32'h55AA55AA; iob_wstrb = 4'hF;
      tick();
      iob_valid = 0;
      tick();
      bvalid = 1; bresp = 2'b10;
      tick();
      bvalid = 0; bresp = 2'b00;
      chk("e_err_set", iob_err, 1);
      chk("e_ready", iob_ready, 1);
      iob_valid = 1; iob_addr = 16'h0010; iob_wstrb = 4'h0; arready = 1;
      tick();
      iob_valid = 0;
      tick();
      rvalid = 1; rdata = 32'h12345678;
      tick();
      rvalid = 0;
      chk("e_read_rvalid", iob_rvalid, 1);
      chk("e_read_rdata", iob_rdata, 32'h12345678);
      chk("e_err_sticky", iob_err, 1);
      rst = 1;
      tick();
      rst = 0;
      chk("e_err_cleared", iob_err, 0);
      tick();

      // ---------------- rlast=0 on the single beat flags an error
      iob_valid = 1; iob_addr = 16'h0044; iob_wstrb = 4'h0;
      tick();
      iob_valid = 0;
      tick();
      rvalid = 1; rdata = 32'h0BADBEEF; rlast = 0;
      tick();
      rvalid = 0; rlast = 1;
      chk("l_rvalid", iob_rvalid, 1);
      chk("l_err", iob_err, 1);
      rst = 1;
      tick();
      rst = 0;
      tick();

      // ---------------- reset during RD_DATA, late response ignored
      iob_valid = 1; iob_addr = 16'h0048; iob_wstrb = 4'h0;
      tick();
      iob_valid = 0;
      tick();
      chk("a_rready", rready, 1);
      rst = 1;
      tick();
      rst = 0;
      chk("a_rready_off", rready, 0);
      chk("a_arvalid_off", arvalid, 0);
      chk("a_rdata_clr", iob_rdata, 0);
      rvalid = 1; rdata = 32'hBAD0BAD0;
      tick();
      rvalid = 0;
      chk("a_no_rvalid", iob_rvalid, 0);
      chk("a_ready", iob_ready, 1);
      chk("a_no_arvalid", arvalid, 0);
      tick();
      chk("a_no_rvalid2", iob_rvalid, 0);
      chk("a_rdata_kept", iob_rdata, 0);
      iob_valid = 1; iob_addr = 16'h0040; iob_wstrb = 4'h0;
      tick();
      iob_valid = 0;
      chk("a_arvalid_next", arvalid, 1);
      tick();
      rvalid = 1; rdata = 32'hCAFEF00D;
      tick();
      rvalid = 0;
      chk("a_next_rvalid", iob_rvalid, 1);
      chk("a_next_rdata", iob_rdata, 32'hCAFEF00D);

      // ---------------- back-to-back write then read, valid held high
      awready = 1; wready = 1; arready = 1;
      iob_valid = 1; iob_addr = 16'h0050; iob_wdata = 32'hA5A5A5A5; iob_wstrb = 4'hF;
      tick();
      iob_addr = 16'h0060; iob_wstrb = 4'h0;
      chk("b_awvalid", awvalid, 1);
      chk("b_awaddr", awaddr, 16'h0050);
      chk("b_ready_low", iob_ready, 0);
      tick();
      chk("b_no_ar_wresp", arvalid, 0);
      chk("b_bready", bready, 1);
      bvalid = 1;
      tick();
      bvalid = 0;
      chk("b_ready_back", iob_ready, 1);
      chk("b_no_ar_idle", arvalid, 0);
      tick();
      iob_valid = 0;
      chk("b_arvalid", arvalid, 1);
      chk("b_araddr", araddr, 16'h0060);
      chk("b_no_aw", awvalid, 0);
      tick();
      rvalid = 1; rdata = 32'h600D600D;
      tick();
      rvalid = 0;
      chk("b_rvalid", iob_rvalid, 1);
      chk("b_rdata", iob_rdata, 32'h600D600D);
      chk("b_err", iob_err, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
